// File: rtl/clkdiv_nco.sv
// ---------------------------------------------------------------------------
// clkdiv_nco
//   Fractional clock divider built as a phase-accumulator NCO. It derives an
//   output rate F1 from the system clock F0 with no cumulative error. The
//   accumulator adds 'inc' every enabled cycle. Each carry out of the top bit
//   marks one output period.
//
//   Outputs
//     tick      1-cycle strobe, one per output period. Consumers use it as a
//               clock enable.
//     out       approx. 50% duty square wave: the registered accumulator MSB.
//     cfg_ready high while no new increment is waiting to be applied.
//
//   Average tick rate is F0*inc/2^ACC_W. Period jitter is at most one clk
//   cycle.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset, synchronous release
//   en         in   1      1: accumulate; 0: hold acc/out, tick forced 0
//   sync       in   1      phase restart: acc, tick and out go to 0
//   cfg_inc    in   ACC_W  new increment
//   cfg_valid  in   1      cfg_inc valid
//   cfg_ready  out  1      ready to accept cfg_inc (registered)
//   tick       out  1      1-cycle strobe per output period (registered)
//   out        out  1      square wave, registered accumulator MSB
//
// Config handshake (valid/ready)
//   A transfer happens on a rising clk edge where cfg_valid & cfg_ready.
//   After that edge the increment is held as pending and cfg_ready is low.
//   The pending increment becomes active on the first edge with any of:
//     - a wrap (en=1 and carry=1); the wrap step itself still uses the old
//       increment,
//     - sync=1,
//     - a current increment of 0, so a frozen accumulator cannot deadlock.
//   cfg_ready returns high right after the apply edge. The source may hold
//   cfg_valid high while cfg_ready is low; nothing is taken until ready.
// ---------------------------------------------------------------------------
module clkdiv_nco #(
    parameter int unsigned F0    = 50_000_000,
    parameter int unsigned F1    = 115_200,
    parameter int          ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             tick,
    output logic             out
);

    // Default increment round(F1*2^ACC_W/F0). The 64-bit arithmetic keeps the
    // shifted numerator exact for every legal ACC_W.
    localparam logic [63:0] INC0_W =
        ((64'(F1) << ACC_W) + (64'(F0) >> 1)) / 64'(F0);
    localparam logic [ACC_W-1:0] INC0 = INC0_W[ACC_W-1:0];

    if (ACC_W < 8 || ACC_W > 32) begin : g_bad_acc_w
        $error("clkdiv_nco: ACC_W must be in 8..32");
    end

    if (INC0_W >= (64'd1 << (ACC_W - 1))) begin : g_bad_f1
        $error("clkdiv_nco: F1 must not exceed F0/2");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic [ACC_W-1:0] inc_q,      inc_d;
    logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
    logic             pend_q,     pend_d;
    logic             ready_q,    ready_d;
    logic             tick_q,     tick_d;
    logic             out_q,      out_d;

    // -----------------------------------------------------------------------
    // Datapath and control
    // -----------------------------------------------------------------------
    logic [ACC_W:0] sum;     // one extra bit holds the carry (wrap)
    logic           carry;
    logic           accept;  // handshake transfer this edge
    logic           apply;   // pending increment becomes active this edge

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        carry  = sum[ACC_W];
        accept = cfg_valid & ready_q;
        // accept needs pend_q=0 and apply needs pend_q=1, so the two never
        // happen on the same edge.
        apply  = pend_q & (sync | (en & carry) | (inc_q == '0));
    end

    always_comb begin
        acc_d      = acc_q;
        tick_d     = 1'b0;
        out_d      = out_q;
        inc_d      = inc_q;
        pend_d     = pend_q;
        pend_inc_d = pend_inc_q;

        // Phase accumulator. sync has priority over en.
        if (sync) begin
            acc_d = '0;
            out_d = 1'b0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            tick_d = carry;
            out_d  = sum[ACC_W-1];
        end

        // Increment update. The wrap step above already used the old inc_q.
        if (apply) begin
            inc_d  = pend_inc_q;
            pend_d = 1'b0;
        end else if (accept) begin
            pend_inc_d = cfg_inc;
            pend_d     = 1'b1;
        end

        // cfg_ready is its own flop that always mirrors ~pend.
        ready_d = ~pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            inc_q      <= INC0;
            pend_inc_q <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b1;
            tick_q     <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            pend_inc_q <= pend_inc_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            tick_q     <= tick_d;
            out_q      <= out_d;
        end
    end

    assign cfg_ready = ready_q;
    assign tick      = tick_q;
    assign out       = out_q;

endmodule

// File: tb/tb_clkdiv_nco.sv
// Bench for clkdiv_nco. An 8-bit instance (F0=400, F1=100, so the default
// increment is 64) carries the directed scenarios. A default 32-bit instance
// carries the long tick-count scenario.
module tb_clkdiv_nco;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic rst8_n  = 1'b0;
    logic rst32_n = 1'b0;

    // ---------------- 8-bit instance ----------------
    logic       en8        = 1'b0;
    logic       sync8      = 1'b0;
    logic [7:0] cfg_inc8   = 8'd0;
    logic       cfg_valid8 = 1'b0;
    logic       cfg_ready8;
    logic       tick8;
    logic       out8;

    clkdiv_nco #(.F0(400), .F1(100), .ACC_W(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst8_n),
        .en        (en8),
        .sync      (sync8),
        .cfg_inc   (cfg_inc8),
        .cfg_valid (cfg_valid8),
        .cfg_ready (cfg_ready8),
        .tick      (tick8),
        .out       (out8)
    );

    // ---------------- 32-bit default instance ----------------
    logic        en32        = 1'b0;
    logic        sync32      = 1'b0;
    logic [31:0] cfg_inc32   = 32'd0;
    logic        cfg_valid32 = 1'b0;
    logic        cfg_ready32;
    logic        tick32;
    logic        out32;

    clkdiv_nco dut32 (
        .clk       (clk),
        .rst_n     (rst32_n),
        .en        (en32),
        .sync      (sync32),
        .cfg_inc   (cfg_inc32),
        .cfg_valid (cfg_valid32),
        .cfg_ready (cfg_ready32),
        .tick      (tick32),
        .out       (out32)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 8-bit instance ----------------
    // The phase is an ordinary integer in [0,256). A step that reaches 256 or
    // more is one output period.
    localparam int INC0_8 = 64;   // round(100*256/400)

    int m_phase    = 0;
    int m_inc      = INC0_8;
    int m_pend_inc = 0;
    bit m_pend     = 1'b0;
    bit m_tick     = 1'b0;
    bit m_out      = 1'b0;
    logic [2:0] exp_q[$];

    task automatic model_reset();
        m_phase = 0; m_inc = INC0_8; m_pend_inc = 0;
        m_pend = 1'b0; m_tick = 1'b0; m_out = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int  next_phase;
        bit  wrapped;
        bit  take;
        next_phase = m_phase + m_inc;
        wrapped    = en8 && (next_phase >= 256);
        take       = m_pend && (sync8 || wrapped || m_inc == 0);
        if (sync8) begin
            m_phase = 0; m_tick = 1'b0; m_out = 1'b0;
        end else if (en8) begin
            m_phase = next_phase % 256;
            m_tick  = wrapped;
            m_out   = (m_phase >= 128);
        end else begin
            m_tick = 1'b0;
        end
        if (take) begin
            m_inc = m_pend_inc; m_pend = 1'b0;
        end else if (!m_pend && cfg_valid8) begin
            m_pend_inc = int'(cfg_inc8); m_pend = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst8_n) begin
        if (!rst8_n) model_reset();
        else         model_step();
        exp_q.push_back({m_tick, m_out, ~m_pend});
    end

    // Compare process: one expected triple per edge, checked mid-cycle.
    logic [2:0] exp_v;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("mdl_tick",  tick8,      exp_v[2]);
            chk("mdl_out",   out8,       exp_v[1]);
            chk("mdl_ready", cfg_ready8, exp_v[0]);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are stable then.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycles until tick8 is seen (limit+1 when it never arrives).
    task automatic cycles_to_tick(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (tick8) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic send_cfg8(input logic [7:0] v);
        cfg_valid8 = 1'b1;
        cfg_inc8   = v;
        cyc();
        cfg_valid8 = 1'b0;
    endtask

    task automatic pulse_sync8();
        sync8 = 1'b1;
        cyc();
        sync8 = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] pat_tick64 = 8'b1000_1000;  // inc 64 from 0: tick every 4th
    logic [7:0] pat_out64  = 8'b0110_0110;  // out 0,1,1,0 repeating
    logic [7:0] pat_tick96 = 8'b1010_0100;  // inc 96 from 0: ticks at 3,6,8
    logic [7:0] seen;
    int n;
    int cnt;

    initial begin
        repeat (3) cyc();
        chk("rst_tick",  tick8,      0);
        chk("rst_out",   out8,       0);
        chk("rst_ready", cfg_ready8, 1);
        rst8_n  = 1'b1;
        rst32_n = 1'b1;

        // 1: default inc 64
        en8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t1_tick", tick8, pat_tick64[i]);
            chk("t1_out",  out8,  pat_out64[i]);
        end

        // 2: inc 96, applied by sync
        send_cfg8(8'd96);
        chk("t2_busy", cfg_ready8, 0);
        pulse_sync8();
        chk("t2_ready", cfg_ready8, 1);
        chk("t2_sync_out", out8, 0);
        cnt = 0;
        for (int i = 0; i < 96; i++) begin
            cyc();
            if (i < 8) seen[i] = tick8;
            cnt += int'(tick8);
        end
        chk("t2_pattern", seen, pat_tick96);
        chk("t2_count", cnt, 36);

        // 4: config mid-period, second valid while busy
        pulse_sync8();
        cfg_valid8 = 1'b1;
        cfg_inc8   = 8'd64;
        cyc();                          // accepted, phase 96
        chk("t4_busy_a", cfg_ready8, 0);
        cfg_inc8 = 8'd32;               // still valid, must be ignored
        cyc();                          // phase 192
        chk("t4_busy_b", cfg_ready8, 0);
        chk("t4_no_tick", tick8, 0);
        cfg_valid8 = 1'b0;
        cyc();                          // wrap with old inc 96 -> phase 32
        chk("t4_wrap_tick", tick8, 1);
        chk("t4_ready_back", cfg_ready8, 1);
        cycles_to_tick(40, n);
        chk("t4_period1", n, 4);
        cycles_to_tick(40, n);
        chk("t4_period2", n, 4);

        // 5: en low for 10 cycles mid-period
        pulse_sync8();
        cyc();
        cyc();                          // phase 128
        chk("t5_out_hi", out8, 1);
        en8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t5_hold_tick", tick8, 0);
            chk("t5_hold_out",  out8,  1);
        end
        en8 = 1'b1;
        cycles_to_tick(40, n);
        chk("t5_shifted", 2 + 10 + n, 14);

        // 5b: sync applies a pending increment
        send_cfg8(8'd32);               // phase 64
        chk("t5_busy", cfg_ready8, 0);
        cyc();                          // phase 128
        chk("t5_out_pre", out8, 1);
        pulse_sync8();
        chk("t5_sync_out",   out8,       0);
        chk("t5_sync_tick",  tick8,      0);
        chk("t5_sync_ready", cfg_ready8, 1);
        cycles_to_tick(40, n);
        chk("t5_new_period", n, 8);

        // 6: inc 0 freezes, then a new increment applies on the next edge
        send_cfg8(8'd0);
        pulse_sync8();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            cnt += int'(tick8);
        end
        chk("t6_frozen_ticks", cnt, 0);
        en8 = 1'b0;
        send_cfg8(8'd64);
        chk("t6_busy", cfg_ready8, 0);
        cyc();
        chk("t6_applied", cfg_ready8, 1);
        en8 = 1'b1;
        cycles_to_tick(40, n);
        chk("t6_resume", n, 4);

        // 6b: reset while a config is pending
        send_cfg8(8'd32);               // phase 64
        cyc();                          // phase 128
        chk("t6_pend", cfg_ready8, 0);
        chk("t6_out_pre", out8, 1);
        rst8_n = 1'b0;
        #1;
        chk("t6_rst_tick",  tick8,      0);
        chk("t6_rst_out",   out8,       0);
        chk("t6_rst_ready", cfg_ready8, 1);
        cyc();
        rst8_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t6_inc0_tick", tick8, pat_tick64[i]);
            chk("t6_inc0_out",  out8,  pat_out64[i]);
        end

        // 3: default 32-bit instance, long count
        en32 = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 43402; i++) begin
            cyc();
            cnt += int'(tick32);
        end
        chk("t3_ticks_43402", cnt, 99);
        cyc();
        cnt += int'(tick32);
        chk("t3_ticks_43403", cnt, 100);
        en32 = 1'b0;

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
